// File: rtl/fire_anim_ctrl_if.sv
// Control bundle between movement logic and the sprite animation sequencer.
// The master drives per-frame intent; the slave (fire_anim_ctrl) returns renderer controls.
interface fire_anim_ctrl_if;
    logic       frame_start;
    logic       freeze;
    logic       left_key;
    logic       right_key;
    logic [1:0] animation_frame;
    logic       left_moving;
    logic       right_moving;
    logic       facing_left;
    logic       walking;

    modport master (
        output frame_start, freeze, left_key, right_key,
        input  animation_frame, left_moving, right_moving, facing_left, walking
    );

    modport slave (
        input  frame_start, freeze, left_key, right_key,
        output animation_frame, left_moving, right_moving, facing_left, walking
    );
endinterface

// File: rtl/fire_anim_ctrl.sv
// Player sprite animation sequencer; updates only on unfrozen frame_start pulses.
// Optional macro ANIM_PINGPONG_EN selects a bouncing walk sequence instead of wrapping.
module fire_anim_ctrl #(
    parameter int FRAME_HOLD = 6,
    parameter int NUM_FRAMES = 3
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    fire_anim_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_t;

    localparam logic [5:0] HOLD_LAST  = 6'(FRAME_HOLD - 1);
    localparam logic [1:0] FRAME_LAST = 2'(NUM_FRAMES - 1);

    state_t     state_r;
    logic [1:0] frame_r;
    logic [5:0] hold_r;
    logic       facing_left_r;
    logic       left_moving_r;
    logic       right_moving_r;
    logic       walking_r;

    logic       update_s;
    logic       dir_left_s;
    logic       dir_right_s;
    logic       dir_any_s;
    logic       reversed_s;

`ifdef ANIM_PINGPONG_EN
    logic       dir_up_r;

    // Returns {next_dir_up, next_frame}; turns around at either end of the row.
    function automatic logic [2:0] bounce_next(input logic [1:0] f, input logic up);
        logic [2:0] res;
        if (up) begin
            if (f >= FRAME_LAST) begin
                res = {1'b0, FRAME_LAST - 2'd1};
            end else begin
                res = {1'b1, f + 2'd1};
            end
        end else begin
            if (f == 2'd0) begin
                res = {1'b1, 2'd1};
            end else begin
                res = {1'b0, f - 2'd1};
            end
        end
        return res;
    endfunction
`else
    function automatic logic [1:0] wrap_next(input logic [1:0] f);
        logic [1:0] res;
        if (f >= FRAME_LAST) begin
            res = 2'd0;
        end else begin
            res = f + 2'd1;
        end
        return res;
    endfunction
`endif

    assign update_s    = bus.frame_start & ~bus.freeze;
    assign dir_left_s  = bus.left_key & ~bus.right_key;
    assign dir_right_s = bus.right_key & ~bus.left_key;
    assign dir_any_s   = dir_left_s | dir_right_s;
    assign reversed_s  = (dir_left_s & ~facing_left_r) | (dir_right_s & facing_left_r);

    // Sequencer FSM: state, pose, hold count and registered renderer controls.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            frame_r        <= 2'd0;
            hold_r         <= 6'd0;
            facing_left_r  <= 1'b0;
            left_moving_r  <= 1'b0;
            right_moving_r <= 1'b0;
            walking_r      <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            dir_up_r       <= 1'b1;
`endif
        end else if (update_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (dir_any_s) begin
                        state_r        <= ST_WALK;
                        frame_r        <= 2'd0;
                        hold_r         <= 6'd0;
                        facing_left_r  <= dir_left_s;
                        left_moving_r  <= dir_left_s;
                        right_moving_r <= dir_right_s;
                        walking_r      <= 1'b1;
`ifdef ANIM_PINGPONG_EN
                        dir_up_r       <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WALK: begin
                    if (!dir_any_s) begin
                        // Facing is kept so the idle sprite stays mirrored correctly.
                        state_r        <= ST_IDLE;
                        frame_r        <= 2'd0;
                        hold_r         <= 6'd0;
                        left_moving_r  <= 1'b0;
                        right_moving_r <= 1'b0;
                        walking_r      <= 1'b0;
                    end else if (reversed_s) begin
                        frame_r        <= 2'd0;
                        hold_r         <= 6'd0;
                        facing_left_r  <= ~facing_left_r;
                        left_moving_r  <= ~facing_left_r;
                        right_moving_r <= facing_left_r;
`ifdef ANIM_PINGPONG_EN
                        dir_up_r       <= 1'b1;
`endif
                    end else if (hold_r >= HOLD_LAST) begin
                        hold_r <= 6'd0;
`ifdef ANIM_PINGPONG_EN
                        {dir_up_r, frame_r} <= bounce_next(frame_r, dir_up_r);
`else
                        frame_r <= wrap_next(frame_r);
`endif
                    end else begin
                        hold_r <= hold_r + 6'd1;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    frame_r        <= 2'd0;
                    hold_r         <= 6'd0;
                    left_moving_r  <= 1'b0;
                    right_moving_r <= 1'b0;
                    walking_r      <= 1'b0;
`ifdef ANIM_PINGPONG_EN
                    dir_up_r       <= 1'b1;
`endif
                end
            endcase
        end
    end

    assign bus.animation_frame = frame_r;
    assign bus.left_moving     = left_moving_r;
    assign bus.right_moving    = right_moving_r;
    assign bus.facing_left     = facing_left_r;
    assign bus.walking         = walking_r;

endmodule

// File: tb/tb_fire_anim_ctrl.sv
// Scoreboard bench for fire_anim_ctrl with directed update vectors.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_fire_anim_ctrl;

    typedef struct {
        logic [1:0] frame;
        logic       lm;
        logic       rm;
        logic       fl;
        logic       walk;
        string      name;
    } exp_t;

    logic vga_clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    fire_anim_ctrl_if anim_bus ();

    fire_anim_ctrl #(
        .FRAME_HOLD (6),
        .NUM_FRAMES (3)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (anim_bus)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    task automatic check(input exp_t e);
        checks++;
        if (anim_bus.animation_frame !== e.frame || anim_bus.left_moving !== e.lm ||
            anim_bus.right_moving !== e.rm || anim_bus.facing_left !== e.fl ||
            anim_bus.walking !== e.walk) begin
            errors++;
            $display("FAIL %s: got frame=%0d lm=%b rm=%b fl=%b walk=%b, expected frame=%0d lm=%b rm=%b fl=%b walk=%b",
                     e.name, anim_bus.animation_frame, anim_bus.left_moving,
                     anim_bus.right_moving, anim_bus.facing_left, anim_bus.walking,
                     e.frame, e.lm, e.rm, e.fl, e.walk);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] f, input logic lm, input logic rm,
                                input logic fl, input logic w, input string nm);
        exp_t e;
        e.frame = f;
        e.lm    = lm;
        e.rm    = rm;
        e.fl    = fl;
        e.walk  = w;
        e.name  = nm;
        return e;
    endfunction

    // Monitor: outputs are stable at the falling edge after each update.
    always @(negedge vga_clk) begin
        if (exp_q.size() != 0) begin
            check(exp_q.pop_front());
        end
    end

    // One frame_start pulse with the given keys/freeze, then queue the expected outputs.
    task automatic upd(input logic l, input logic r, input logic fz,
                       input logic [1:0] f, input logic lm, input logic rm,
                       input logic fl, input logic w, input string nm);
        @(negedge vga_clk);
        anim_bus.left_key    = l;
        anim_bus.right_key   = r;
        anim_bus.freeze      = fz;
        anim_bus.frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        anim_bus.frame_start = 1'b0;
        anim_bus.freeze      = 1'b0;
        exp_q.push_back(mk(f, lm, rm, fl, w, nm));
        @(negedge vga_clk);
    endtask

    initial begin
        logic [1:0] ef;
        checks = 0;
        errors = 0;
        reset_n              = 1'b0;
        anim_bus.frame_start = 1'b0;
        anim_bus.freeze      = 1'b0;
        anim_bus.left_key    = 1'b0;
        anim_bus.right_key   = 1'b0;
        #12;
        check(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state"));
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Key pulses that never coincide with an update are ignored.
        for (int i = 0; i < 3; i++) begin
            upd(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("offedge_%0d", i));
            anim_bus.right_key = 1'b1;
            @(negedge vga_clk);
            anim_bus.right_key = 1'b0;
        end

        // Walk right up to frame 2 (updates 1, 7, 13 advance the pose).
        for (int k = 1; k <= 13; k++) begin
            ef = 2'((k - 1) / 6);
            upd(1'b0, 1'b1, 1'b0, ef, 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("walk_r_%0d", k));
        end

        // Reverse to the left from frame 2.
        upd(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, "reverse");
        for (int j = 1; j <= 6; j++) begin
            ef = (j == 6) ? 2'd1 : 2'd0;
            upd(1'b1, 1'b0, 1'b0, ef, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("rev_hold_%0d", j));
        end

        upd(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, "both_keys");
        upd(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, "idle_keep_face");

        // Full right walk through the end of the row.
        for (int k = 1; k <= 19; k++) begin
            if (k < 19) begin
                ef = 2'((k - 1) / 6);
            end else begin
`ifdef ANIM_PINGPONG_EN
                ef = 2'd1;
`else
                ef = 2'd0;
`endif
            end
            upd(1'b0, 1'b1, 1'b0, ef, 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("row_r_%0d", k));
        end
        upd(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "stop");

        // Walk left to hold=3, then freeze with a reversing key pressed.
        for (int k = 1; k <= 4; k++) begin
            upd(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("pre_frz_%0d", k));
        end
        for (int k = 1; k <= 10; k++) begin
            upd(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("frozen_%0d", k));
        end
        for (int k = 1; k <= 3; k++) begin
            ef = (k == 3) ? 2'd1 : 2'd0;
            upd(1'b1, 1'b0, 1'b0, ef, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("post_frz_%0d", k));
        end
        for (int k = 1; k <= 6; k++) begin
            ef = (k == 6) ? 2'd2 : 2'd1;
            upd(1'b1, 1'b0, 1'b0, ef, 1'b1, 1'b0, 1'b1, 1'b1, $sformatf("to_f2_%0d", k));
        end

        // Asynchronous reset away from any clock edge while at frame 2.
        @(posedge vga_clk);
        #3;
        anim_bus.left_key = 1'b0;
        reset_n = 1'b0;
        #1;
        check(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "async_reset"));
        @(negedge vga_clk);
        reset_n = 1'b1;
        upd(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset_idle");
        upd(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, "after_reset_walk");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge vga_clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
